// File: rtl/delay_assign_pkg.sv
// Shared types for the delayed-assignment scheduler: slot record, mode enum
// and default widths that size the slot record.
package delay_assign_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int DLY_W_DEF  = 4;
  localparam int PEND_W     = $clog2(DEPTH_DEF + 1);

  typedef enum logic {
    TRANSPORT = 1'b0,
    INERTIAL  = 1'b1
  } mode_e;

  // Sized by the package defaults; the top-level parameters must match them.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
    logic [DLY_W_DEF-1:0]  count;
  } slot_t;

endpackage

// File: rtl/delay_assign_sched_age_arb.sv
// Age tracking for the pending-event slots: keeps a relative age matrix and
// picks the youngest firing slot and the oldest valid slot (both one-hot).
module dly_age_arb #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_fire,
  input  logic [DEPTH-1:0] i_alloc_oh,
  output logic [DEPTH-1:0] o_young_fire_oh,
  output logic [DEPTH-1:0] o_old_valid_oh
);

  // r_older[i][j] = 1 when slot i was issued before slot j.
  // Entries for free slots are stale and only ever compared against valid ones.
  logic [DEPTH-1:0][DEPTH-1:0] r_older;
  logic [DEPTH-1:0][DEPTH-1:0] w_older_nxt;

  always_comb begin
    o_young_fire_oh = '0;
    o_old_valid_oh  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_young_fire_oh[i] = i_fire[i];
      o_old_valid_oh[i]  = i_valid[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i) begin
          if (i_fire[j] && !r_older[j][i])
            o_young_fire_oh[i] = 1'b0;
          if (i_valid[j] && !r_older[i][j])
            o_old_valid_oh[i] = 1'b0;
        end
      end
    end
  end

  // A newly loaded slot becomes younger than every other slot.
  always_comb begin
    w_older_nxt = r_older;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_alloc_oh[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          w_older_nxt[k][i] = 1'b0;
          w_older_nxt[i][k] = (i != k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_older <= '0;
    else
      r_older <= w_older_nxt;
  end

endmodule

// File: rtl/delay_assign_sched.sv
// Clocked equivalent of intra-assignment delay: requesters post (value, delay)
// and the youngest event whose delay expires commits to the shared register q.
module delay_assign_sched
  import delay_assign_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_data,
  input  logic [DLY_W-1:0]           req_delay,
  input  logic                       req_inertial,
  input  logic                       flush,
  output logic [WIDTH-1:0]           q,
  output logic                       q_update,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int PEND_BITS = $clog2(DEPTH + 1);

  slot_t                r_slot [DEPTH];
  slot_t                w_slot_nxt [DEPTH];
  logic [WIDTH-1:0]     r_q;
  logic                 r_q_update;
  logic [PEND_BITS-1:0] r_pending;

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_fire;
  logic [DEPTH-1:0] w_free_oh;
  logic [DEPTH-1:0] w_alloc_oh;
  logic [DEPTH-1:0] w_young_oh;
  logic [DEPTH-1:0] w_old_oh;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [WIDTH-1:0] w_fire_data;
  logic             w_accept;
  logic             w_commit;
  mode_e            w_mode;

  // Every valid slot predates the current edge, so a zero count fires now.
  always_comb begin
    w_valid = '0;
    w_fire  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_slot[i].valid;
      w_fire[i]  = r_slot[i].valid && (r_slot[i].count == '0);
    end
  end

  assign w_mode    = req_inertial ? INERTIAL : TRANSPORT;
  assign req_ready = !flush && ((|(~w_valid)) || (w_mode == INERTIAL));
  assign w_accept  = req_valid && req_ready;
  assign w_commit  = !flush && (|w_fire);

  // Lowest-index free slot; iterate downward so the lowest index wins.
  always_comb begin
    w_free_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  // A full slot array can only accept in inertial mode: overwrite the oldest.
  assign w_alloc_oh = !w_accept      ? '0 :
                      (|w_free_oh)   ? w_free_oh : w_old_oh;

  dly_age_arb #(.DEPTH(DEPTH)) u_age_arb (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_valid         (w_valid),
    .i_fire          (w_fire),
    .i_alloc_oh      (w_alloc_oh),
    .o_young_fire_oh (w_young_oh),
    .o_old_valid_oh  (w_old_oh)
  );

  always_comb begin
    w_fire_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_young_oh[i])
        w_fire_data = r_slot[i].data;
  end

  always_comb begin
    w_valid_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_nxt[i] = r_slot[i];
      if (flush) begin
        w_slot_nxt[i].valid = 1'b0;
      end else if (w_alloc_oh[i]) begin
        w_slot_nxt[i].valid = 1'b1;
        w_slot_nxt[i].data  = req_data;
        w_slot_nxt[i].count = req_delay;
      end else if (w_fire[i]) begin
        w_slot_nxt[i].valid = 1'b0;
      end else if (w_accept && (w_mode == INERTIAL)) begin
        w_slot_nxt[i].valid = 1'b0;
      end else if (r_slot[i].valid) begin
        w_slot_nxt[i].count = r_slot[i].count - 1'b1;
      end
      w_valid_nxt[i] = w_slot_nxt[i].valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_slot[i] <= '0;
      r_q        <= '0;
      r_q_update <= 1'b0;
      r_pending  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        r_slot[i] <= w_slot_nxt[i];
      r_q_update <= w_commit;
      if (w_commit)
        r_q <= w_fire_data;
      r_pending <= PEND_BITS'($countones(w_valid_nxt));
    end
  end

  assign q        = r_q;
  assign q_update = r_q_update;
  assign pending  = r_pending;

endmodule

// File: doc/delay_assign_sched.md
# delay_assign_sched

Synthesizable scheduler for delayed assignments to one shared state variable. It is the clocked equivalent of intra-assignment delayed assignment (`v = #D expr`): each requester posts a value and a cycle delay, and the block commits the values to a single output register when their delays expire. It resolves collisions between events and supports transport or inertial cancellation. It drives elaboration/simulation test benches for the procedural-assignment chapter and is reused wherever a register needs delayed, multi-source updates.

## Interface
- `WIDTH`, default 8: width of the assigned value.
- `DEPTH`, default 4: number of pending-event slots.
- `DLY_W`, default 4: width of the delay field, giving a maximum delay of 2^DLY_W−1 cycles.

Ports:
- `clk`  in  1  — single clock; everything is sampled on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — new assignment request.
- `req_ready`  out  1  — the request is accepted when `req_valid && req_ready` at an edge.
- `req_data`  in  WIDTH  — value to assign.
- `req_delay`  in  DLY_W  — delay D in cycles.
- `req_inertial`  in  1  — 1 means cancel all other pending events on accept; 0 means transport (queue).
- `flush`  in  1  — synchronous discard of all pending events.
- `q`  out  WIDTH  — the assigned variable, registered.
- `q_update`  out  1  — one-cycle pulse in the cycle after `q` was written.
- `pending`  out  $clog2(DEPTH+1)  — number of occupied slots, registered.

## Operation
- Each slot holds: `valid`, `data`, `count[DLY_W]`, and an age rank (its issue order).
- On accept, the request loads one free slot, always the lowest-index free slot, with `count = req_delay`. The new slot becomes the youngest.
- At each edge, every valid slot that was already occupied before this edge does the following:
  - if `count == 0`, the slot fires and is freed;
  - otherwise `count` decrements.
- When one or more slots fire at the same edge:
  - `q` takes the data of the youngest firing slot;
  - all firing slots are freed;
  - `q_update` is 1 for the following cycle.
- Inertial accept: at the same edge, every non-firing pending slot is invalidated. Slots that fire at that edge still commit. The new event is then the only pending one.
- `req_ready` is the OR of `!valid` across slots, with `!flush` applied. Slots freed at an edge are reusable from the next cycle.
- In inertial mode the block is always ready when not flushing: if all slots are full, the accepted event overwrites the oldest slot.
- `flush` at an edge:
  - clears all slots;
  - is not blocked by a request, because `req_ready` is low;
  - does not change `q`;
  - wins over firing, so a slot that would fire at that edge is discarded.
- `pending` equals the popcount of the slot valid bits after the edge.

## Timing
- Latency: a request accepted at edge E with delay D writes `q` at edge E+D+1. `q_update` is high during the cycle after edge E+D+1.
- Throughput: one accept per cycle while `req_ready` is high.
- Reset (asynchronous, while `rst_n` is low):
  - `q = 0`, `q_update = 0`, `pending = 0`;
  - all slots invalid, ages cleared;
  - `req_ready = 1` once `flush` is low.
- Reset asserted mid-operation drops all pending events with no commit. The first edge after `rst_n` rises behaves as an idle cycle.
- Full (transport mode): `req_ready = 0`; the requester holds `req_valid`/`req_data` stable.
- Wrap-around: no counter wraps, because `count` saturates at 0 and fires. Age ranks are relative (an age matrix or rank vector), never a free-running sequence number.

## Structure
- Package `delay_assign_pkg` contains:
  - the `slot_t` struct (`valid`, `data`, `count`);
  - the localparam for the pending-count width;
  - a mode enum `{TRANSPORT, INERTIAL}`.
- Sub-module `dly_age_arb`:
  - inputs: DEPTH fire bits and the age state;
  - outputs: the one-hot youngest firing slot and the one-hot oldest valid slot.
- The oldest-valid output drives the inertial overwrite; the age state update also lives in `dly_age_arb`.
- The top level holds the slot registers, counters, `q`, and the flags.

## Test plan
1. Reset, then a transport request with data 0x5A and D=3 accepted at edge 0 → `q` = 0x5A at edge 4, a single `q_update` pulse, `pending` goes 1 → 0.
2. Transport requests 0x11/D=4 then 0x22/D=3 on consecutive edges → both fire at edge 5; `q` = 0x22 (youngest wins); one `q_update` pulse.
3. Fill all 4 slots in transport mode, all with D=7 → `req_ready` = 0 and `pending` = 4. A fifth `req_valid` is held until the first slot fires; it is accepted one cycle later.
4. Transport 0x33/D=6, then an inertial 0x44/D=2 two cycles later → 0x33 is never committed; `q` = 0x44; `pending` = 1 right after the inertial accept.
5. Three pending events, then `flush` for one cycle → `pending` = 0, `q` unchanged, no `q_update`; a request in the same cycle is not accepted.
6. `rst_n` pulsed low asynchronously (between edges) while 2 events are pending → `q`, `pending` and `q_update` go to 0 immediately; no commit after release.
